// File: rtl/jt12_clk_gen_pkg.sv
// Shared definitions for the jt12 clock-enable generator: divider codes,
// strobe decoding and default sequencing parameters.
package jt12_clk_pkg;

    localparam logic [2:0] DIV6 = 3'd6;
    localparam logic [2:0] DIV3 = 3'd3;
    localparam logic [2:0] DIV2 = 3'd2;

    typedef enum logic [2:0] {
        DIV_CODE_2 = DIV2,
        DIV_CODE_3 = DIV3,
        DIV_CODE_6 = DIV6
    } div_code_e;

    typedef struct packed {
        logic      valid;
        div_code_e code;
    } div_req_t;

    localparam int DEF_SLOW_DIV = 24;
    localparam int DEF_RST_CEN  = 2;

    // Coincident strobes resolve as /6 over /3 over /2.
    function automatic div_req_t decode_strobes(input logic s6, input logic s3, input logic s2);
        div_req_t r;
        r.valid = s6 | s3 | s2;
        if (s6) begin
            r.code = DIV_CODE_6;
        end else if (s3) begin
            r.code = DIV_CODE_3;
        end else begin
            r.code = DIV_CODE_2;
        end
        return r;
    endfunction

endpackage

// File: rtl/jt12_clk_gen_rst_seq.sv
// Internal reset sequencer: holds rst_int high until RST_CEN clock enables
// have been seen after the external reset is released.
module jt12_rst_seq
    import jt12_clk_pkg::*;
#(
    parameter int RST_CEN = DEF_RST_CEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cen,
    output logic rst_int
);

    localparam int             RST_W    = 4;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CEN - 1);

    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic             rst_int_q, rst_int_d;

    always_comb begin
        rst_cnt_d = rst_cnt_q;
        rst_int_d = rst_int_q;
        if (rst_int_q && cen) begin
            if (rst_cnt_q == RST_LAST) begin
                rst_int_d = 1'b0;
            end else begin
                rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_cnt_q <= '0;
            rst_int_q <= 1'b1;
        end else begin
            rst_cnt_q <= rst_cnt_d;
            rst_int_q <= rst_int_d;
        end
    end

    assign rst_int = rst_int_q;

endmodule

// File: rtl/jt12_clk_gen.sv
// Clock-enable generator for the FM core: run-time selectable prescaler,
// sample-rate enable and internal reset. Optional mid-period enable cen_p2
// is built when JT12_CLK_PHASE2_EN is defined.
module jt12_clk_gen
    import jt12_clk_pkg::*;
#(
    parameter int CNT_W    = 3,
    parameter int DEF_DIV  = 6,
    parameter int SLOW_DIV = DEF_SLOW_DIV,
    parameter int RST_CEN  = DEF_RST_CEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_n6,
    input  logic             set_n3,
    input  logic             set_n2,
    output logic             cen,
    output logic             cen_slow,
    output logic [CNT_W-1:0] div_cur,
    output logic             rst_int
`ifdef JT12_CLK_PHASE2_EN
    ,
    output logic             cen_p2
`endif
);

    localparam int               SLOW_W    = $clog2(SLOW_DIV);
    localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_DIV - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  div_cur_q, div_cur_d;
    logic [CNT_W-1:0]  pending_q, pending_d;
    logic [SLOW_W-1:0] slow_cnt_q, slow_cnt_d;
    logic              cen_q, cen_d;
    logic              cen_slow_q, cen_slow_d;
    logic              wrap;
    div_req_t          req;

    // The divider only changes on the wrap edge, so every cen period is whole.
    always_comb begin
        req        = decode_strobes(set_n6, set_n3, set_n2);
        wrap       = (cnt_q == (div_cur_q - CNT_ONE));
        cnt_d      = wrap ? '0 : (cnt_q + CNT_ONE);
        div_cur_d  = wrap ? pending_q : div_cur_q;
        pending_d  = req.valid ? CNT_W'(req.code) : pending_q;
        cen_d      = wrap;
        cen_slow_d = 1'b0;
        slow_cnt_d = slow_cnt_q;
        if (wrap) begin
            if (slow_cnt_q == SLOW_LAST) begin
                slow_cnt_d = '0;
                cen_slow_d = 1'b1;
            end else begin
                slow_cnt_d = slow_cnt_q + SLOW_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_cur_q  <= DEF_DIV_C;
            pending_q  <= DEF_DIV_C;
            slow_cnt_q <= '0;
            cen_q      <= 1'b0;
            cen_slow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            pending_q  <= pending_d;
            slow_cnt_q <= slow_cnt_d;
            cen_q      <= cen_d;
            cen_slow_q <= cen_slow_d;
        end
    end

    jt12_rst_seq #(
        .RST_CEN (RST_CEN)
    ) u_rst_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (cen_q),
        .rst_int (rst_int)
    );

`ifdef JT12_CLK_PHASE2_EN
    logic cen_p2_q, cen_p2_d;

    // Registered from cnt like cen, so at /2 both pulses land together.
    always_comb begin
        cen_p2_d = (cnt_q == (div_cur_q >> 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cen_p2_q <= 1'b0;
        end else begin
            cen_p2_q <= cen_p2_d;
        end
    end

    assign cen_p2 = cen_p2_q;
`endif

    assign cen      = cen_q;
    assign cen_slow = cen_slow_q;
    assign div_cur  = div_cur_q;

endmodule

// File: tb/tb_jt12_clk_gen.sv
// Self-checking bench for jt12_clk_gen: directed vector table, corner-case
// sequences and randomized strobes against an event-scheduled reference model.
module tb_jt12_clk_gen;

    localparam int CNT_W    = 3;
    localparam int DEF_DIV  = 6;
    localparam int SLOW_DIV = 24;
    localparam int RST_CEN  = 2;
    localparam int N_VEC    = 22;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             set_n6;
    logic             set_n3;
    logic             set_n2;
    logic             cen;
    logic             cen_slow;
    logic [CNT_W-1:0] div_cur;
    logic             rst_int;
`ifdef JT12_CLK_PHASE2_EN
    logic             cen_p2;
`endif

    always #5 clk = ~clk;

    jt12_clk_gen #(
        .CNT_W    (CNT_W),
        .DEF_DIV  (DEF_DIV),
        .SLOW_DIV (SLOW_DIV),
        .RST_CEN  (RST_CEN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_n6   (set_n6),
        .set_n3   (set_n3),
        .set_n2   (set_n2),
        .cen      (cen),
        .cen_slow (cen_slow),
        .div_cur  (div_cur),
        .rst_int  (rst_int)
`ifdef JT12_CLK_PHASE2_EN
        ,
        .cen_p2   (cen_p2)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: absolute edge times of the next enable, not a counter.
    int edge_num   = 0;
    int next_wrap  = 0;
    int last_wrap  = 0;
    int div_m      = DEF_DIV;
    int pend_m     = DEF_DIV;
    int cen_total  = 0;
    bit m_cen      = 1'b0;
    bit m_slow     = 1'b0;
    bit m_rst      = 1'b1;
    bit m_p2       = 1'b0;

    typedef struct {
        bit rst_n;
        bit s6;
        bit s3;
        bit s2;
        bit exp_cen;
        int exp_div;
        bit exp_rst;
    } vec_t;

    vec_t vecs [N_VEC];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at edge %0d", name, actual, expected, edge_num);
        end
    endtask

    task automatic model_step(input bit r, input bit s6, input bit s3, input bit s2);
        edge_num++;
        if (!r) begin
            next_wrap = edge_num + DEF_DIV;
            last_wrap = edge_num;
            div_m     = DEF_DIV;
            pend_m    = DEF_DIV;
            cen_total = 0;
            m_cen     = 1'b0;
            m_slow    = 1'b0;
            m_rst     = 1'b1;
            m_p2      = 1'b0;
            return;
        end
        if (m_rst && m_cen && cen_total == RST_CEN) m_rst = 1'b0;
        m_p2 = ((edge_num - 1 - last_wrap) == div_m / 2);
        if (edge_num == next_wrap) begin
            m_cen     = 1'b1;
            div_m     = pend_m;
            last_wrap = edge_num;
            next_wrap = edge_num + div_m;
            cen_total++;
            m_slow    = ((cen_total % SLOW_DIV) == 0);
        end else begin
            m_cen  = 1'b0;
            m_slow = 1'b0;
        end
        if (s6)      pend_m = 6;
        else if (s3) pend_m = 3;
        else if (s2) pend_m = 2;
    endtask

    // One clock: drive inputs, let the edge happen, compare against the model.
    task automatic applyStimulus(input bit r, input bit s6, input bit s3, input bit s2);
        rst_n  = r;
        set_n6 = s6;
        set_n3 = s3;
        set_n2 = s2;
        @(posedge clk);
        model_step(r, s6, s3, s2);
        #1;
        checkOutput("model_cen", cen, m_cen);
        checkOutput("model_cen_slow", cen_slow, m_slow);
        checkOutput("model_div_cur", div_cur, div_m);
        checkOutput("model_rst_int", rst_int, m_rst);
`ifdef JT12_CLK_PHASE2_EN
        checkOutput("model_cen_p2", cen_p2, m_p2);
`endif
    endtask

    task automatic waitCen(output int n);
        n = 0;
        do begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end while (cen !== 1'b1 && n < 20);
        checks++;
        if (cen !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait_cen: no cen within %0d cycles (got %0d expected 1)", n, cen);
        end
    endtask

    initial begin
        int n;
        int slow_first;
        int slow_second;

        rst_n  = 1'b0;
        set_n6 = 1'b0;
        set_n3 = 1'b0;
        set_n2 = 1'b0;

        // Directed reset-release sequence, index k is the cycle after edge k+1.
        for (int k = 0; k < N_VEC; k++) begin
            int cyc;
            cyc = k + 1;
            vecs[k].rst_n   = 1'b1;
            vecs[k].s6      = 1'b0;
            vecs[k].s3      = (cyc == 8);
            vecs[k].s2      = 1'b0;
            vecs[k].exp_cen = (cyc == 6 || cyc == 12 || cyc == 15 || cyc == 18 || cyc == 21);
            vecs[k].exp_div = (cyc >= 12) ? 3 : 6;
            vecs[k].exp_rst = (cyc <= 12);
        end

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_cen", cen, 0);
        checkOutput("reset_cen_slow", cen_slow, 0);
        checkOutput("reset_div_cur", div_cur, 6);
        checkOutput("reset_rst_int", rst_int, 1);

        for (int k = 0; k < N_VEC; k++) begin
            applyStimulus(vecs[k].rst_n, vecs[k].s6, vecs[k].s3, vecs[k].s2);
            checkOutput("vec_cen", cen, vecs[k].exp_cen);
            checkOutput("vec_div_cur", div_cur, vecs[k].exp_div);
            checkOutput("vec_rst_int", rst_int, vecs[k].exp_rst);
        end

        // Coincident n6 and n2: n6 wins at the next wrap.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        waitCen(n);
        checkOutput("prio_n6_over_n2", div_cur, 6);

        // n3 then n2 inside one /6 period: the later one wins.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        waitCen(n);
        checkOutput("last_strobe_wins", div_cur, 2);
        waitCen(n);
        checkOutput("period_div2", n, 2);

        // One-cycle reset at /2 with a request pending.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("midrst_cen", cen, 0);
        checkOutput("midrst_cen_slow", cen_slow, 0);
        checkOutput("midrst_div_cur", div_cur, 6);
        checkOutput("midrst_rst_int", rst_int, 1);
        waitCen(n);
        checkOutput("midrst_first_cen_delay", n, 6);
        checkOutput("pending_discarded", div_cur, 6);
        checkOutput("rst_int_held_cen1", rst_int, 1);
        waitCen(n);
        checkOutput("midrst_second_cen_delay", n, 6);
        checkOutput("rst_int_held_cen2", rst_int, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_int_release", rst_int, 0);

        // Sample-rate enable spacing at /6 from a fresh reset.
        slow_first  = -1;
        slow_second = -1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 300; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            if (cen_slow === 1'b1) begin
                if (slow_first < 0) slow_first = i;
                else if (slow_second < 0) slow_second = i;
            end
        end
        checkOutput("slow_first_cycle", slow_first, 144);
        checkOutput("slow_second_cycle", slow_second, 288);

        // Randomized strobes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bit r, s6, s3, s2;
            r  = ($urandom_range(0, 199) != 0);
            s6 = ($urandom_range(0, 23) == 0);
            s3 = ($urandom_range(0, 15) == 0);
            s2 = ($urandom_range(0, 15) == 0);
            applyStimulus(r, s6, s3, s2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
